// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the FASA ALU.
//   op_t  - 3-bit operation select driven by the instruction decoder.
//   ALU_W - datapath width; the arithmetic in alu assumes 8 bits.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        RXOR  = 3'd1,
        OR    = 3'd2,
        LOAD  = 3'd3,
        STORE = 3'd4,
        BGTZ  = 3'd5,
        SLL   = 3'd6,
        AND   = 3'd7
    } op_t;

endpackage

// File: rtl/alu_shl.sv
// alu_shl: combinational logical left shifter with zero fill.
//   a        in  8  value to shift
//   amt      in  8  shift amount; any amount >= 8 shifts everything out
//   y        out 8  a << amt
//   last_out out 1  last bit shifted out of the top: a[8-amt] for 1<=amt<=8,
//                   otherwise 0
module alu_shl
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] amt,
    output logic [ALU_W-1:0] y,
    output logic             last_out
);

    // For amt in 1..8 the last bit to leave is a[8-amt]; only the low
    // three bits of that index are needed because 8-amt lies in 0..7.
    logic [3:0] idx;

    always_comb begin
        idx      = 4'd8 - amt[3:0];
        y        = '0;
        last_out = 1'b0;
        if (amt < 8'd8)
            y = a << amt[2:0];
        if (amt >= 8'd1 && amt <= 8'd8)
            last_out = a[idx[2:0]];
    end

endmodule

// File: rtl/alu.sv
// alu: 8-bit ALU for the FASA datapath.
//   Clk    in  1  clock; SC_out updates on the rising edge
//   Reset  in  1  asynchronous active-high reset, clears SC_out
//   InputA in  8  operand A (register-file read port 1)
//   InputB in  8  operand B (register-file read port 2 / immediate)
//   SC_in  in  1  carry-in, used by ADD only when chaining is built in
//   OP     in  3  operation select (op_t)
//   Out    out 8  combinational result
//   Zero   out 1  combinational, Out == 0
//   SC_out out 1  registered carry / shift-out flag
// Build option: define ALU_SC_CHAIN_EN to make ADD compute A + B + SC_in
// for multi-byte add chains; otherwise SC_in is ignored.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic         SC_in,
    input  logic [2:0]   OP,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         SC_out
);

`ifdef ALU_SC_CHAIN_EN
    localparam logic CHAIN_EN = 1'b1;
`else
    localparam logic CHAIN_EN = 1'b0;
`endif

    logic         cin;
    logic [W:0]   sum;
    logic [W-1:0] shl_y;
    logic         shl_last;

    // Masking with the build constant keeps SC_in read in both builds.
    assign cin = SC_in & CHAIN_EN;
    assign sum = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, cin};

    alu_shl u_shl (
        .a        (InputA),
        .amt      (InputB),
        .y        (shl_y),
        .last_out (shl_last)
    );

    always_comb begin
        Out = '0;
        // An unknown OP matches no item and falls to the default, so Out = 0.
        case (OP)
            ADD:     Out = sum[W-1:0];
            RXOR:    Out = {{(W-1){1'b0}}, ^InputB};
            OR:      Out = InputA | InputB;
            LOAD:    Out = InputB;
            STORE:   Out = InputA;
            BGTZ:    Out = {{(W-1){1'b0}}, (InputA != '0)};
            SLL:     Out = shl_y;
            AND:     Out = InputA & InputB;
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            SC_out <= 1'b0;
        else if (OP == ADD)
            SC_out <= sum[W];
        else if (OP == SLL)
            SC_out <= shl_last;
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
module tb_alu;

    logic       Clk;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       SC_in;
    logic [2:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic       SC_out;

    int checks = 0;
    int errors = 0;

    alu dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .InputA (InputA),
        .InputB (InputB),
        .SC_in  (SC_in),
        .OP     (OP),
        .Out    (Out),
        .Zero   (Zero),
        .SC_out (SC_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Apply operands just after a falling edge, settle 1ns.
    task automatic apply(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
        @(negedge Clk);
        OP = op; InputA = a; InputB = b; SC_in = cin;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        apply(3'd0, 8'hFF, 8'h01, 1'b0);
        clock_edge();
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: SC_out=%b expected=0", SC_out);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_add_sweep();
        logic [7:0] exp;
        for (int a = 230; a <= 255; a++) begin
            for (int b = 230; b <= 255; b++) begin
                apply(3'd0, 8'(a), 8'(b), 1'b0);
                exp = 8'(a + b);
                checks++;
                if (Out !== exp) begin
                    errors++;
                    $display("FAIL add_sweep %h+%h: Out=%h expected=%h", a, b, Out, exp);
                end
            end
        end
        apply(3'd0, 8'hE6, 8'hE6, 1'b0);
        checks++;
        if (Out !== 8'hCC) begin
            errors++;
            $display("FAIL add_e6e6: Out=%h expected=cc", Out);
        end
    endtask

    task automatic test_carry();
        apply(3'd0, 8'hFF, 8'h01, 1'b0);
        checks++;
        if (Out !== 8'h00 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL carry_out: Out=%h Zero=%b expected 00/1", Out, Zero);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b1) begin
            errors++;
            $display("FAIL carry_flag: SC_out=%b expected=1", SC_out);
        end
        // Non-ADD/SLL ops must leave the flag alone.
        apply(3'd2, 8'h00, 8'h00, 1'b0);
        clock_edge();
        checks++;
        if (SC_out !== 1'b1) begin
            errors++;
            $display("FAIL carry_hold: SC_out=%b expected=1", SC_out);
        end
        // Asynchronous clear in the low phase, no clock edge before the check.
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: SC_out=%b expected=0", SC_out);
        end
        #1;
        Reset = 1'b0;
        // Sum without carry clears the flag.
        apply(3'd0, 8'hFF, 8'h01, 1'b0);
        clock_edge();
        apply(3'd0, 8'h01, 8'h01, 1'b0);
        clock_edge();
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL carry_clear: SC_out=%b expected=0", SC_out);
        end
    endtask

    task automatic test_logic();
        apply(3'd2, 8'hF0, 8'h0F, 1'b0);
        checks++;
        if (Out !== 8'hFF || Zero !== 1'b0) begin
            errors++;
            $display("FAIL or: Out=%h Zero=%b expected ff/0", Out, Zero);
        end
        apply(3'd7, 8'hF0, 8'h0F, 1'b0);
        checks++;
        if (Out !== 8'h00 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL and_zero: Out=%h Zero=%b expected 00/1", Out, Zero);
        end
        apply(3'd7, 8'hF3, 8'h3C, 1'b0);
        checks++;
        if (Out !== 8'h30) begin
            errors++;
            $display("FAIL and: Out=%h expected=30", Out);
        end
        apply(3'd1, 8'hFF, 8'h07, 1'b0);
        checks++;
        if (Out !== 8'h01) begin
            errors++;
            $display("FAIL rxor_07: Out=%h expected=01", Out);
        end
        apply(3'd1, 8'hFF, 8'h03, 1'b0);
        checks++;
        if (Out !== 8'h00 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL rxor_03: Out=%h Zero=%b expected 00/1", Out, Zero);
        end
    endtask

    task automatic test_pass();
        apply(3'd3, 8'h12, 8'h34, 1'b0);
        checks++;
        if (Out !== 8'h34) begin
            errors++;
            $display("FAIL load: Out=%h expected=34", Out);
        end
        apply(3'd4, 8'h12, 8'h34, 1'b0);
        checks++;
        if (Out !== 8'h12) begin
            errors++;
            $display("FAIL store: Out=%h expected=12", Out);
        end
        apply(3'd5, 8'h00, 8'h34, 1'b0);
        checks++;
        if (Out !== 8'h00 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL bgtz_0: Out=%h Zero=%b expected 00/1", Out, Zero);
        end
        apply(3'd5, 8'h80, 8'h00, 1'b0);
        checks++;
        if (Out !== 8'h01 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL bgtz_80: Out=%h Zero=%b expected 01/0", Out, Zero);
        end
    endtask

    task automatic test_sll();
        apply(3'd6, 8'h81, 8'h01, 1'b0);
        checks++;
        if (Out !== 8'h02) begin
            errors++;
            $display("FAIL sll_1: Out=%h expected=02", Out);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b1) begin
            errors++;
            $display("FAIL sll_1_flag: SC_out=%b expected=1", SC_out);
        end
        apply(3'd6, 8'hFF, 8'hC8, 1'b0);
        checks++;
        if (Out !== 8'h00 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL sll_c8: Out=%h Zero=%b expected 00/1", Out, Zero);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL sll_c8_flag: SC_out=%b expected=0", SC_out);
        end
        apply(3'd6, 8'hFF, 8'h08, 1'b0);
        checks++;
        if (Out !== 8'h00) begin
            errors++;
            $display("FAIL sll_8: Out=%h expected=00", Out);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b1) begin
            errors++;
            $display("FAIL sll_8_flag: SC_out=%b expected=1", SC_out);
        end
        apply(3'd6, 8'h81, 8'h00, 1'b0);
        checks++;
        if (Out !== 8'h81) begin
            errors++;
            $display("FAIL sll_0: Out=%h expected=81", Out);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL sll_0_flag: SC_out=%b expected=0", SC_out);
        end
        apply(3'd6, 8'h83, 8'h07, 1'b0);
        checks++;
        if (Out !== 8'h80) begin
            errors++;
            $display("FAIL sll_7: Out=%h expected=80", Out);
        end
        clock_edge();
        checks++;
        if (SC_out !== 1'b1) begin
            errors++;
            $display("FAIL sll_7_flag: SC_out=%b expected=1", SC_out);
        end
    endtask

    task automatic test_chain();
        logic [7:0] exp;
`ifdef ALU_SC_CHAIN_EN
        exp = 8'h31;
`else
        exp = 8'h30;
`endif
        apply(3'd0, 8'h10, 8'h20, 1'b1);
        checks++;
        if (Out !== exp) begin
            errors++;
            $display("FAIL chain_add: Out=%h expected=%h", Out, exp);
        end
        // SC_in must not leak into other ops.
        apply(3'd2, 8'h10, 8'h20, 1'b1);
        checks++;
        if (Out !== 8'h30) begin
            errors++;
            $display("FAIL chain_or: Out=%h expected=30", Out);
        end
    endtask

    initial begin
        Reset = 1'b1; OP = 3'd0; InputA = 8'h00; InputB = 8'h00; SC_in = 1'b0;
        #1;
        checks++;
        if (SC_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: SC_out=%b expected=0", SC_out);
        end
        test_reset();
        test_add_sweep();
        test_carry();
        test_logic();
        test_pass();
        test_sll();
        test_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
